// File: rtl/pool_stream_ctrl.sv
// Frame sequencer: streams DIM*DIM image pixels into max_pool and captures pooled results.
// Optional build macro POOL_CTRL_PERF_EN adds a saturating busy-cycle counter port cycle_cnt.
module pool_stream_ctrl #(
  parameter  int unsigned DIM       = 16,
  parameter  int unsigned K         = 2,
  parameter  int unsigned STRIDE    = 2,
  parameter  int unsigned DRAIN_MAX = 64,
  localparam int unsigned NPIX      = DIM * DIM,
  localparam int unsigned OD        = (DIM - K) / STRIDE + 1,
  localparam int unsigned NOUT      = OD * OD,
  localparam int unsigned AW        = $clog2(NPIX),
  localparam int unsigned RW        = $clog2(NOUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          img_rd_en,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_data,
  output logic          pool_clr,
  output logic [8:0]    pool_pxl,
  input  logic [8:0]    pool_out,
  input  logic          pool_valid,
  output logic          res_we,
  output logic [RW-1:0] res_addr,
  output logic [8:0]    res_data
`ifdef POOL_CTRL_PERF_EN
  ,
  output logic [31:0]   cycle_cnt
`endif
);

  localparam int unsigned DW = $clog2(DRAIN_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            busy_q, done_q, error_q, rd_en_q, clr_q;
  logic [AW-1:0]   addr_q;
  logic [AW:0]     pix_q;
  logic [RW:0]     res_cnt_q, res_cnt_d;
  logic [DW:0]     drain_q;
  logic            capture;

  always_comb begin
    capture = 1'b0;
    if ((state_q == S_STREAM || state_q == S_DRAIN) && pool_valid &&
        (res_cnt_q < (RW+1)'(NOUT)))
      capture = 1'b1;
    res_cnt_d = res_cnt_q + (RW+1)'(capture);
  end

  // Read data lags the address by one cycle, so the pixel driven to max_pool
  // in STREAM cycle n is the word addressed in the previous cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      clr_q     <= 1'b1;
      addr_q    <= '0;
      pix_q     <= '0;
      res_cnt_q <= '0;
      drain_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      res_cnt_q <= res_cnt_d;
      case (state_q)
        S_IDLE: begin
          clr_q <= 1'b1;
          if (start) begin
            state_q   <= S_CLEAR;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            rd_en_q   <= 1'b1;
            addr_q    <= '0;
            pix_q     <= '0;
            res_cnt_q <= '0;
            drain_q   <= '0;
          end
        end
        S_CLEAR: begin
          state_q <= S_STREAM;
          clr_q   <= 1'b0;
          addr_q  <= AW'(1);
          rd_en_q <= 1'b1;
        end
        S_STREAM: begin
          if (pix_q == (AW+1)'(NPIX - 1)) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= '0;
          end else begin
            pix_q <= pix_q + 1'b1;
            if (addr_q < AW'(NPIX - 1)) begin
              addr_q  <= addr_q + 1'b1;
              rd_en_q <= 1'b1;
            end else begin
              rd_en_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (res_cnt_d == (RW+1)'(NOUT)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (drain_q == (DW+1)'(DRAIN_MAX - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          clr_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          clr_q   <= 1'b1;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign img_rd_en = rd_en_q;
  assign img_addr  = addr_q;
  assign pool_clr  = clr_q;
  assign pool_pxl  = (state_q == S_STREAM) ? {1'b0, img_data} : '0;
  assign res_we    = capture;
  assign res_addr  = res_cnt_q[RW-1:0];
  assign res_data  = pool_out;

`ifdef POOL_CTRL_PERF_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cyc_q <= '0;
    end else if ((state_q == S_CLEAR || state_q == S_STREAM || state_q == S_DRAIN) &&
                 (cyc_q != '1)) begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Directed bench for pool_stream_ctrl: image memory, 2x2/2 max-pool model and stub valid modes.
module tb_pool_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       busy, done, error, img_rd_en;
  logic [7:0] img_addr, img_data;
  logic       pool_clr;
  logic [8:0] pool_pxl, pool_out;
  logic       pool_valid;
  logic       res_we;
  logic [5:0] res_addr;
  logic [8:0] res_data;
`ifdef POOL_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
`endif

  always #5 clk = ~clk;

  pool_stream_ctrl #(
    .DIM(16), .K(2), .STRIDE(2), .DRAIN_MAX(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_data(img_data),
    .pool_clr(pool_clr), .pool_pxl(pool_pxl), .pool_out(pool_out), .pool_valid(pool_valid),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
`ifdef POOL_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  // Image memory: pixel[n] = n+1 mod 256, one-cycle read latency.
  always @(posedge clk) if (img_rd_en) img_data <= img_addr + 8'd1;

  // 2x2 stride-2 max-pool model, result registered one cycle after the window's last pixel.
  int unsigned mp_idx;
  logic [8:0]  mp_hq, mp_h, mp_res;
  logic [8:0]  mp_row [8];
  logic        mp_vld;
  assign mp_h = (pool_pxl > mp_hq) ? pool_pxl : mp_hq;

  always @(posedge clk) begin
    if (pool_clr) begin
      mp_idx <= 0;
      mp_vld <= 1'b0;
    end else begin
      mp_vld <= 1'b0;
      if (mp_idx < 256) begin
        if (mp_idx[0] == 1'b0) mp_hq <= pool_pxl;
        else if (mp_idx[4] == 1'b0) mp_row[mp_idx[3:1]] <= mp_h;
        else begin
          mp_res <= (mp_h > mp_row[mp_idx[3:1]]) ? mp_h : mp_row[mp_idx[3:1]];
          mp_vld <= 1'b1;
        end
        mp_idx <= mp_idx + 1;
      end
    end
  end

  // mode 0: pool model, 1: valid never, 2: valid stuck high with constant data
  logic [1:0] mode;
  assign pool_valid = (mode == 2'd0) ? mp_vld : (mode == 2'd2);
  assign pool_out   = (mode == 2'd0) ? mp_res : 9'h1AB;

  logic       mon_clr;
  int         n_rd, n_wr, n_done, n_busy, rd_exp;
  logic       rd_bad, wr_bad;
  logic [8:0] cap [64];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_rd <= 0; n_wr <= 0; n_done <= 0; n_busy <= 0; rd_exp <= 0;
      rd_bad <= 1'b0; wr_bad <= 1'b0;
    end else begin
      if (img_rd_en) begin
        if (img_addr != rd_exp[7:0] || rd_exp > 255) rd_bad <= 1'b1;
        rd_exp <= rd_exp + 1;
        n_rd   <= n_rd + 1;
      end
      if (res_we) begin
        if (n_wr < 64) begin
          cap[n_wr] <= res_data;
          if (res_addr != n_wr[5:0]) wr_bad <= 1'b1;
        end else begin
          wr_bad <= 1'b1;
        end
        n_wr <= n_wr + 1;
      end
      if (done) n_done <= n_done + 1;
      if (busy) n_busy <= n_busy + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk); #2 mon_clr = 1'b1;
    @(negedge clk); #2 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      @(negedge clk); #1;
    end
    chk_eq(tag, n_done != 0, 1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_good_frame(input string tag);
    chk_eq({tag, "_reads"}, n_rd, 256);
    chk_eq({tag, "_rd_order"}, rd_bad, 0);
    chk_eq({tag, "_writes"}, n_wr, 64);
    chk_eq({tag, "_wr_order"}, wr_bad, 0);
    chk_eq({tag, "_res0"}, cap[0], 18);
    chk_eq({tag, "_res1"}, cap[1], 20);
    chk_eq({tag, "_res9"}, cap[9], 52);
    chk_eq({tag, "_res62"}, cap[62], 254);
    chk_eq({tag, "_res63"}, cap[63], 255);
    chk_eq({tag, "_done_cnt"}, n_done, 1);
    chk_eq({tag, "_error"}, error, 0);
    chk_eq({tag, "_busy_cycles"}, n_busy, 258);
    chk_eq({tag, "_clr_idle"}, pool_clr, 1);
`ifdef POOL_CTRL_PERF_EN
    chk_eq({tag, "_cycle_cnt"}, cycle_cnt, 258);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; mode = 2'd0; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_error", error, 0);
    chk_eq("rst_rd_en", img_rd_en, 0);
    chk_eq("rst_res_we", res_we, 0);
    chk_eq("rst_img_addr", img_addr, 0);
    chk_eq("rst_res_addr", res_addr, 0);
    chk_eq("rst_pool_clr", pool_clr, 1);
    chk_eq("rst_pool_pxl", pool_pxl, 0);
`ifdef POOL_CTRL_PERF_EN
    chk_eq("rst_cycle_cnt", cycle_cnt, 0);
`endif
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame
    clear_mon();
    pulse_start();
    wait_done("t1_done_seen", 600);
    check_good_frame("t1");
`ifdef POOL_CTRL_PERF_EN
    repeat (5) @(negedge clk);
    #1 chk_eq("t1_cycle_cnt_hold", cycle_cnt, 258);
`endif

    // Start while busy is ignored
    clear_mon();
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("t2_done_seen", 600);
    check_good_frame("t2");

    // No valid: drain timeout
    mode = 2'd1;
    clear_mon();
    pulse_start();
    wait_done("t3_done_seen", 800);
    chk_eq("t3_writes", n_wr, 0);
    chk_eq("t3_error", error, 1);
    chk_eq("t3_done_cnt", n_done, 1);
    chk_eq("t3_busy_cycles", n_busy, 321);
`ifdef POOL_CTRL_PERF_EN
    chk_eq("t3_cycle_cnt", cycle_cnt, 321);
`endif
    mode = 2'd0;
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); #1;
    chk_eq("t3_error_cleared", error, 0);
    chk_eq("t3_busy_after_start", busy, 1);
    start = 1'b0;
    wait_done("t3b_done_seen", 600);
    check_good_frame("t3b");

    // Valid stuck high
    mode = 2'd2;
    @(negedge clk); #1;
    chk_eq("t4_idle_no_write", res_we, 0);
    clear_mon();
    pulse_start();
    wait_done("t4_done_seen", 600);
    chk_eq("t4_writes", n_wr, 64);
    chk_eq("t4_wr_order", wr_bad, 0);
    chk_eq("t4_res0", cap[0], 9'h1AB);
    chk_eq("t4_res63", cap[63], 9'h1AB);
    chk_eq("t4_error", error, 0);
    chk_eq("t4_done_cnt", n_done, 1);
    chk_eq("t4_busy_cycles", n_busy, 258);
    chk_eq("t4_post_no_write", res_we, 0);
    mode = 2'd0;

    // Reset mid-frame
    clear_mon();
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (img_addr == 8'd100) break;
    end
    chk_eq("t5_addr100_reached", img_addr, 100);
    reset = 1'b0;
    #1;
    chk_eq("t5_busy", busy, 0);
    chk_eq("t5_pool_clr", pool_clr, 1);
    chk_eq("t5_rd_en", img_rd_en, 0);
    chk_eq("t5_img_addr", img_addr, 0);
    repeat (5) @(negedge clk);
    #1 chk_eq("t5_no_done", n_done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    pulse_start();
    wait_done("t5b_done_seen", 600);
    check_good_frame("t5b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
